multnxm_pipe: RTL and testbench
===============================

MULTNXM_PIPE -- requirements
Module: multnxm_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 18, operand A width, 2..32.
- BW, 18, operand B width, 2..32.
- STAGES, 3, pipeline register stages, 2..6.
- ACCW, 48, accumulator width, ≥ AW+BW+1.

REQ-002 Ports SHALL be, one per line:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid && o_ready.
- i_multa_sgn  in  1  1 = i_multa is two's complement, 0 = unsigned.
- i_multb_sgn  in  1  1 = i_multb is two's complement, 0 = unsigned.
- i_multa  in  AW  operand A.
- i_multb  in  BW  operand B.
- i_acc_en  in  1  add this beat's product into the accumulator.
- i_acc_clr  in  1  with i_acc_en, the accumulator restarts at this product.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts when o_valid && i_ready.
- o_product  out  AW+BW  exact product of the beat.
- o_acc  out  ACCW  accumulator value after this beat.
- o_acc_ovf  out  1  sticky signed accumulator overflow.

Function
REQ-003 Product SHALL be exact in AW+BW bits:
- Each operand is extended by one bit (sign bit if its _sgn = 1, else zero) before multiplying.
- The result is truncated to AW+BW bits.
- With both _sgn = 0 the result is unsigned; otherwise it is two's complement.

REQ-004 Sign flags, operands, i_acc_en and i_acc_clr SHALL be captured together on acceptance and travel with the beat through every stage.

REQ-005 Pipeline advance SHALL be global: advance = i_ready || !o_valid, and o_ready = advance.

REQ-006 Latency SHALL be exactly STAGES cycles from acceptance to o_valid when advance stays high; bubbles are not collapsed.

REQ-007 While o_valid && !i_ready, o_valid, o_product, o_acc and o_acc_ovf SHALL be held stable and no stage SHALL change.

REQ-008 Throughput SHALL be one beat per cycle with no stall.

REQ-009 The accumulator SHALL update only when a beat enters the output stage:
- acc_en = 1, clr = 0: acc ← acc + ext(product).
- acc_en = 1, clr = 1: acc ← ext(product).
- acc_en = 0: acc unchanged.
- i_acc_clr without i_acc_en is ignored.

REQ-010 ext() SHALL sign-extend the product to ACCW when either sign flag is 1, and zero-extend it otherwise.

REQ-011 The accumulator SHALL be treated as signed ACCW bits, with wrap-around on overflow.

REQ-012 o_acc_ovf SHALL set when an addition overflows as signed ACCW, and SHALL clear only on reset or on a beat with acc_en = clr = 1, which re-evaluates it as 0.

REQ-013 o_acc SHALL present the post-update accumulator value alongside the beat's o_product.

REQ-014 A bubble entering the output stage SHALL drop o_valid and SHALL NOT alter acc or o_acc_ovf.

REQ-015 Boundary: the most negative × most negative signed case (e.g. AW=BW=18: −131072 × −131072 = 2^34) SHALL be representable without overflow of o_product.

REQ-016 Sign flags SHALL be allowed to change every beat; no mode state is kept outside the pipeline.

Reset
REQ-017 i_rst high SHALL asynchronously clear:
- all stage valid bits, o_valid = 0;
- o_product = 0, o_acc = 0, o_acc_ovf = 0;
- all pipeline data to 0.

REQ-018 While i_rst is high, o_ready SHALL read 1, since o_valid = 0; beats presented during reset are discarded.

REQ-019 Reset asserted mid-stream SHALL drop all in-flight beats; the first beat accepted after release SHALL emerge STAGES cycles later.

Verification
REQ-020 Directed scenarios the bench SHALL cover (AW=BW=18, STAGES=3, ACCW=48 unless stated):
- Unsigned 0x3FFFF × 0x3FFFF, i_ready = 1 -> o_product = 0xFFFF80001 three cycles after acceptance.
- Signed −1 × unsigned 0x3FFFF -> o_product = −262143 (0xFFFFC0001); signed −131072 × signed −131072 -> o_product = 0x400000000.
- Accumulate: beats 5×7 (clr = 1), 3×(−4) signed, 10×10, all acc_en = 1 -> o_acc = 35, 23, 123 on successive outputs.
- Backpressure: 4 back-to-back beats, i_ready low for 5 cycles after the first o_valid -> o_ready low during the stall, no beat lost or duplicated, o_* stable.
- Overflow: ACCW = 37, repeated unsigned 0x3FFFF × 0x3FFFF accumulation -> o_acc_ovf sets on the second add and stays set until a clr beat.
- Reset at cycle 2 of a 3-beat stream -> o_valid = 0 immediately, o_acc = 0, nothing emerges; a new beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/multnxm_pipe.sv
// Pipelined AW x BW multiplier with per-beat signedness and a signed wrap-around accumulator.
// Global stall: every stage advances together when the output is free or being accepted.
module multnxm_pipe #(
  parameter int unsigned AW     = 18,
  parameter int unsigned BW     = 18,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ACCW   = 48
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_multa_sgn,
  input  logic               i_multb_sgn,
  input  logic [AW-1:0]      i_multa,
  input  logic [BW-1:0]      i_multb,
  input  logic               i_acc_en,
  input  logic               i_acc_clr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [AW+BW-1:0]   o_product,
  output logic [ACCW-1:0]    o_acc,
  output logic               o_acc_ovf
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned E  = STAGES - 2;  // chain index of the beat entering the output stage

  logic          advance;
  logic          in_v_q, in_asgn_q, in_bsgn_q, in_en_q, in_clr_q;
  logic [AW-1:0] in_a_q;
  logic [BW-1:0] in_b_q;
  logic [PW-1:0] op_a, op_b;

  // Chain index 0 is the combinational product of the input stage; index i>0 is stage i+1.
  logic [STAGES-1:0] ch_v;
  logic [PW-1:0]     ch_p [STAGES];
  logic [STAGES-2:0] ch_sx, ch_en, ch_clr;

  logic [ACCW-1:0] acc_q, acc_d, prod_ext, sum;
  logic            ovf_q, ovf_d;

  assign advance = i_ready | ~ch_v[STAGES-1];
  assign o_ready = advance;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_v_q    <= 1'b0;
      in_asgn_q <= 1'b0;
      in_bsgn_q <= 1'b0;
      in_en_q   <= 1'b0;
      in_clr_q  <= 1'b0;
      in_a_q    <= '0;
      in_b_q    <= '0;
    end else if (advance) begin
      in_v_q    <= i_valid;
      in_asgn_q <= i_multa_sgn;
      in_bsgn_q <= i_multb_sgn;
      in_en_q   <= i_acc_en;
      in_clr_q  <= i_acc_clr;
      in_a_q    <= i_multa;
      in_b_q    <= i_multb;
    end
  end

  // Extending both operands to PW bits and multiplying modulo 2^PW yields the exact product.
  always_comb begin
    op_a = {{BW{in_asgn_q & in_a_q[AW-1]}}, in_a_q};
    op_b = {{AW{in_bsgn_q & in_b_q[BW-1]}}, in_b_q};
  end

  assign ch_v[0]   = in_v_q;
  assign ch_p[0]   = op_a * op_b;
  assign ch_sx[0]  = in_asgn_q | in_bsgn_q;
  assign ch_en[0]  = in_en_q;
  assign ch_clr[0] = in_clr_q;

  for (genvar i = 1; i < STAGES; i++) begin : g_stage
    logic          v_q;
    logic [PW-1:0] p_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v_q <= 1'b0;
        p_q <= '0;
      end else if (advance) begin
        v_q <= ch_v[i-1];
        p_q <= ch_p[i-1];
      end
    end

    assign ch_v[i] = v_q;
    assign ch_p[i] = p_q;

    // The output stage needs no flags: they are consumed as the beat enters it.
    if (i < STAGES - 1) begin : g_flags
      logic sx_q, en_q, clr_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sx_q  <= 1'b0;
          en_q  <= 1'b0;
          clr_q <= 1'b0;
        end else if (advance) begin
          sx_q  <= ch_sx[i-1];
          en_q  <= ch_en[i-1];
          clr_q <= ch_clr[i-1];
        end
      end

      assign ch_sx[i]  = sx_q;
      assign ch_en[i]  = en_q;
      assign ch_clr[i] = clr_q;
    end
  end

  always_comb begin
    prod_ext = {{(ACCW-PW){ch_sx[E] & ch_p[E][PW-1]}}, ch_p[E]};
    sum      = acc_q + prod_ext;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (advance && ch_v[E] && ch_en[E]) begin
      if (ch_clr[E]) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum;
        if ((acc_q[ACCW-1] == prod_ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1])) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_valid   = ch_v[STAGES-1];
  assign o_product = ch_p[STAGES-1];
  assign o_acc     = acc_q;
  assign o_acc_ovf = ovf_q;

endmodule

// File: tb/tb_multnxm_pipe.sv
// Directed bench for multnxm_pipe: a default instance plus an ACCW=37 instance sharing inputs.
module tb_multnxm_pipe;

  logic        clk, rst;
  logic        i_valid, i_ready, sa, sb, acc_en, acc_clr;
  logic [17:0] ma, mb;
  logic        o_ready, o_valid, o_ovf;
  logic [35:0] o_product;
  logic [47:0] o_acc;
  logic        x_ready, x_valid, x_ovf;
  logic [35:0] x_product;
  logic [36:0] x_acc;

  int errors = 0;
  int checks = 0;

  // Stream stimulus table and expectations.
  logic [17:0] va [8];
  logic [17:0] vb [8];
  logic        vsa [8];
  logic        vsb [8];
  logic        ven [8];
  logic        vclr [8];
  logic [63:0] eprod [8];
  logic [63:0] eacc [8];
  logic        eovf [8];

  multnxm_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_multa_sgn(sa), .i_multb_sgn(sb), .i_multa(ma), .i_multb(mb),
    .i_acc_en(acc_en), .i_acc_clr(acc_clr), .o_valid(o_valid), .i_ready(i_ready),
    .o_product(o_product), .o_acc(o_acc), .o_acc_ovf(o_ovf)
  );

  multnxm_pipe #(.AW(18), .BW(18), .STAGES(3), .ACCW(37)) dut_o (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(x_ready),
    .i_multa_sgn(sa), .i_multb_sgn(sb), .i_multa(ma), .i_multb(mb),
    .i_acc_en(acc_en), .i_acc_clr(acc_clr), .o_valid(x_valid), .i_ready(i_ready),
    .o_product(x_product), .o_acc(x_acc), .o_acc_ovf(x_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic asg,
                      input logic bsg, input logic en, input logic clr);
    i_valid = 1'b1; ma = a; mb = b; sa = asg; sb = bsg; acc_en = en; acc_clr = clr;
  endtask

  task automatic idle();
    i_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic set_row(input int k, input logic [17:0] a, input logic [17:0] b,
                         input logic asg, input logic bsg, input logic en, input logic clr,
                         input logic [63:0] p, input logic [63:0] acc, input logic ovf);
    va[k] = a; vb[k] = b; vsa[k] = asg; vsb[k] = bsg; ven[k] = en; vclr[k] = clr;
    eprod[k] = p; eacc[k] = acc; eovf[k] = ovf;
  endtask

  // Back-to-back beats; each must emerge exactly three cycles after acceptance.
  task automatic run_stream(input int n, input bit use_o, input string tag);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) beat(va[i], vb[i], vsa[i], vsb[i], ven[i], vclr[i]);
      else idle();
      tick();
      if (i == 1) chk({tag, "_lat"}, {63'd0, use_o ? x_valid : o_valid}, 64'd0);
      if (i >= 2) begin
        if (!use_o) begin
          chk($sformatf("%s_v%0d", tag, i - 2), {63'd0, o_valid}, 64'd1);
          chk($sformatf("%s_p%0d", tag, i - 2), {28'd0, o_product}, eprod[i-2]);
          chk($sformatf("%s_a%0d", tag, i - 2), {16'd0, o_acc}, eacc[i-2]);
        end else begin
          chk($sformatf("%s_v%0d", tag, i - 2), {63'd0, x_valid}, 64'd1);
          chk($sformatf("%s_p%0d", tag, i - 2), {28'd0, x_product}, eprod[i-2]);
          chk($sformatf("%s_a%0d", tag, i - 2), {27'd0, x_acc}, eacc[i-2]);
          chk($sformatf("%s_o%0d", tag, i - 2), {63'd0, x_ovf}, {63'd0, eovf[i-2]});
        end
      end
    end
    tick();
    chk({tag, "_drain"}, {63'd0, use_o ? x_valid : o_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_ready = 1'b1;
    ma = '0; mb = '0; sa = 1'b0; sb = 1'b0;
    idle();
    #2;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_prod", {28'd0, o_product}, 64'd0);
    chk("rst_acc", {16'd0, o_acc}, 64'd0);
    chk("rst_ovf", {63'd0, o_ovf}, 64'd0);
    beat(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0);  // discarded: presented in reset
    tick(); tick();
    idle();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_discard", {63'd0, o_valid}, 64'd0);

    // Unsigned max x max.
    set_row(0, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF_FFF8_0001, 64'd0, 1'b0);
    run_stream(1, 1'b0, "umax");

    // Signed -1 x unsigned max, and most-negative squared.
    set_row(0, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 64'hF_FFFC_0001, 64'd0, 1'b0);
    set_row(1, 18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h4_0000_0000, 64'd0, 1'b0);
    run_stream(2, 1'b0, "sgn");

    // Accumulate 35, 23, 123; clr without acc_en is ignored.
    set_row(0, 18'd5, 18'd7, 1'b0, 1'b0, 1'b1, 1'b1, 64'd35, 64'd35, 1'b0);
    set_row(1, 18'd3, 18'h3FFFC, 1'b1, 1'b1, 1'b1, 1'b0, 64'hF_FFFF_FFF4, 64'd23, 1'b0);
    set_row(2, 18'd10, 18'd10, 1'b0, 1'b0, 1'b1, 1'b0, 64'd100, 64'd123, 1'b0);
    set_row(3, 18'd2, 18'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'd4, 64'd123, 1'b0);
    run_stream(4, 1'b0, "acc");

    // Backpressure: stall 5 cycles once the first beat is at the output.
    beat(18'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    beat(18'd2, 18'd2, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    beat(18'd3, 18'd3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("bp_first", {28'd0, o_product}, 64'd1);
    beat(18'd4, 18'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ready = 1'b0;
    #1;
    chk("bp_ready_lo", {63'd0, o_ready}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_v%0d", c), {63'd0, o_valid}, 64'd1);
      chk($sformatf("bp_p%0d", c), {28'd0, o_product}, 64'd1);
      chk($sformatf("bp_a%0d", c), {16'd0, o_acc}, 64'd123);
      chk($sformatf("bp_r%0d", c), {63'd0, o_ready}, 64'd0);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_ready_hi", {63'd0, o_ready}, 64'd1);
    tick();
    idle();
    chk("bp_out2", {28'd0, o_product}, 64'd4);
    tick();
    chk("bp_out3", {28'd0, o_product}, 64'd9);
    tick();
    chk("bp_out4", {28'd0, o_product}, 64'd16);
    chk("bp_out4_v", {63'd0, o_valid}, 64'd1);
    tick();
    chk("bp_drain", {63'd0, o_valid}, 64'd0);

    // Reset mid-stream drops everything in flight.
    beat(18'd5, 18'd5, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    beat(18'd6, 18'd6, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    rst = 1'b1;
    #1;
    chk("mid_valid", {63'd0, o_valid}, 64'd0);
    chk("mid_acc", {16'd0, o_acc}, 64'd0);
    chk("mid_ready", {63'd0, o_ready}, 64'd1);
    beat(18'd7, 18'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_empty%0d", c), {63'd0, o_valid}, 64'd0);
    end
    set_row(0, 18'd6, 18'd7, 1'b0, 1'b0, 1'b1, 1'b1, 64'd42, 64'd42, 1'b0);
    run_stream(1, 1'b0, "post");

    // Overflow on the 37-bit accumulator; sticky until a clr beat.
    rst = 1'b1; tick(); rst = 1'b0;
    set_row(0, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 64'hF_FFF8_0001,
            64'hF_FFF8_0001, 1'b0);
    set_row(1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 64'hF_FFF8_0001,
            64'h1F_FFF0_0002, 1'b1);
    set_row(2, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 64'hF_FFF8_0001,
            64'hF_FFE8_0003, 1'b1);
    set_row(3, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF_FFF8_0001,
            64'hF_FFE8_0003, 1'b1);
    set_row(4, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 64'hF_FFF8_0001,
            64'hF_FFF8_0001, 1'b0);
    run_stream(5, 1'b1, "ovf");
    chk("wide_no_ovf", {63'd0, o_ovf}, 64'd0);
    chk("wide_acc", {16'd0, o_acc}, 64'hF_FFF8_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
